serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial N-bit subtractor (A - B), LSB first, built around a 1-bit
//  full-subtractor cell and a borrow flip-flop; the inverse of the cascaded
//  1-bit full-adder datapath. One operand pair per start pulse; result after
//  WIDTH shift cycles. Serves as the subtract side of the ALU lab datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk       in   1      rising-edge clock, the only clock
//  rst_n     in   1      synchronous reset, active-low
//  start     in   1      request; sampled only in IDLE
//  a         in   WIDTH  minuend; captured on the accepting edge
//  b         in   WIDTH  subtrahend; captured on the accepting edge
//  busy      out  1      high while in SHIFT
//  done      out  1      one-cycle pulse; result valid
//  diff      out  WIDTH  A - B mod 2^WIDTH; held until next accept
//  borrow    out  1      unsigned borrow-out (A < B unsigned)
//  overflow  out  1      two's-complement overflow
// BEHAVIOUR
//  - Reset: clk edge with rst_n=0 -> state IDLE; busy, done, diff, borrow,
//    overflow, shift regs, borrow FF and counter = 0. Mid-operation reset
//    aborts, no done pulse.
//  - FSM: IDLE -> SHIFT on start=1. SHIFT -> DONE after WIDTH cycles.
//    DONE -> IDLE unconditionally after one cycle.
//  - Accept edge (IDLE, start=1): load a_sh=a, b_sh=b, bw=0, cnt=0,
//    and capture sign bits a[WIDTH-1], b[WIDTH-1].
//  - SHIFT cycle: d = a_sh[0]^b_sh[0]^bw.
//    bw <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&bw).
//    Shift a_sh and b_sh right 1; shift d into the MSB of res_sh.
//    cnt++. Exit to DONE on the edge where cnt reaches WIDTH.
//  - Entering DONE: diff <= res_sh (incl. last bit), borrow <= final bw,
//    overflow <= (sa != sb) && (diff[WIDTH-1] != sa). done=1 for that one
//    cycle only.
//  - Latency: start edge at cycle 0 -> done high during cycle WIDTH+1.
//    Next start accepted no earlier than the following IDLE cycle.
//    Throughput: 1 result per WIDTH+2 cycles.
//  - start while SHIFT or DONE: ignored, not queued.
//  - a/b changes after accept have no effect.
//  - diff/borrow/overflow change only on entering DONE or on reset.
//  - busy and done are never high together. All outputs are registered.
// TESTING
//  1. WIDTH=8, a=100, b=37, start 1 cycle -> done at cycle 9;
//     diff=63, borrow=0, overflow=0.
//  2. a=0x00, b=0x01 -> diff=0xFF, borrow=1, overflow=0.
//  3. a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1;
//     a=0x7F, b=0xFF -> diff=0x80, borrow=1, overflow=1.
//  4. start held high 30 cycles with a/b changing every cycle ->
//     exactly one result per 10 cycles. Each result matches the a/b sampled
//     at its own accept edge.
//  5. rst_n=0 at 4th SHIFT cycle -> next cycle all outputs 0, no done.
//     A fresh start then gives the correct result in 9 cycles.
//  6. Random 1000 pairs, WIDTH=8 and WIDTH=13, vs. reference model
//     (a-b, a<b, signed ovf) -> zero mismatches.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell plus a borrow FF.
// One operand pair per accepted start; result registered on entry to DONE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic [WIDTH-1:0] res_sh_d;
  logic [CW-1:0]    cnt_q;
  logic             bw_q;
  logic             bw_d;
  logic             sa_q;
  logic             sb_q;
  logic             d_bit;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;

  always_comb begin
    d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ bw_q;
    bw_d     = (~a_sh_q[0] & b_sh_q[0])
             | (~(a_sh_q[0] ^ b_sh_q[0]) & bw_q);
    res_sh_d = {d_bit, res_sh_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
            sa_q    <= a[WIDTH-1];
            sb_q    <= b[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= res_sh_d;
          bw_q     <= bw_d;
          cnt_q    <= cnt_q + CW'(1);
          // last bit goes straight into diff, bypassing res_sh_q
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= res_sh_d;
            borrow_q <= bw_d;
            ovf_q    <= (sa_q != sb_q) && (d_bit != sa_q);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: vector table, corner sequences and
// random pairs at WIDTH=8 and WIDTH=13 against an arithmetic model.
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        s8, s13;
  logic [7:0]  a8, b8;
  logic [12:0] a13, b13;
  logic        busy8, done8, bo8, ov8;
  logic        busy13, done13, bo13, ov13;
  logic [7:0]  d8;
  logic [12:0] d13;

  int n_chk;
  int n_fail;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .diff(d8), .borrow(bo8), .overflow(ov8)
  );

  serial_subtractor #(.WIDTH(13)) u13 (
    .clk(clk), .rst_n(rst_n), .start(s13),
    .a(a13), .b(b13), .busy(busy13), .done(done13),
    .diff(d13), .borrow(bo13), .overflow(ov13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
    logic       ov;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // plain-arithmetic reference: modular difference, unsigned compare,
  // signed difference range test
  task automatic model(input int w, input logic [31:0] av, bv,
                       output logic [31:0] dv, output logic br,
                       output logic ov);
    longint m, sa, sb, r, half;
    m    = longint'(1) << w;
    half = m / 2;
    dv   = 32'((longint'(av) - longint'(bv) + m) % m);
    br   = longint'(av) < longint'(bv);
    sa   = (longint'(av) >= half) ? longint'(av) - m : longint'(av);
    sb   = (longint'(bv) >= half) ? longint'(bv) - m : longint'(bv);
    r    = sa - sb;
    ov   = (r > half - 1) || (r < -half);
  endtask

  task automatic run_op(input bit wide, input logic [31:0] av, bv,
                        output logic [31:0] dv, output logic bo,
                        output logic ov, output int lat);
    @(negedge clk);
    if (wide) begin
      a13 = av[12:0]; b13 = bv[12:0]; s13 = 1'b1;
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; s8 = 1'b1;
    end
    @(negedge clk);
    s8 = 1'b0; s13 = 1'b0;
    chk("busy_after_accept", wide ? busy13 : busy8, 1);
    lat = 0;
    while (!(wide ? done13 : done8) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("done_timeout", lat < 40, 1);
    chk("busy_with_done", wide ? busy13 : busy8, 0);
    dv = wide ? 32'(d13) : 32'(d8);
    bo = wide ? bo13 : bo8;
    ov = wide ? ov13 : ov8;
    @(negedge clk);
    chk("done_pulse_width", wide ? done13 : done8, 0);
  endtask

  vec_t        tbl[8];
  logic [31:0] dv, ed;
  logic        bo, ov, eb, eo;
  int          lat;
  logic [7:0]  ah[30], bh[30];
  int          ndone, idx, stray;
  logic [31:0] ra, rb;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    s8 = 0; s13 = 0; a8 = 0; b8 = 0; a13 = 0; b13 = 0;

    tbl[0] = '{8'd100, 8'd37, 8'd63, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tbl[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
    tbl[6] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
    tbl[7] = '{8'h05, 8'h09, 8'hFC, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_diff8", d8, 0);
    chk("rst_flags8", {bo8, ov8}, 0);
    chk("rst_out13", {busy13, done13, d13, bo13, ov13}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, 32'(tbl[i].a), 32'(tbl[i].b), dv, bo, ov, lat);
      chk("tbl_diff", dv, 32'(tbl[i].d));
      chk("tbl_borrow", bo, tbl[i].br);
      chk("tbl_ovf", ov, tbl[i].ov);
      chk("tbl_latency", lat, 8);
    end

    // start held high with operands changing each cycle
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        idx = i - 9;
        chk("t4_done_phase", (idx >= 0) && (idx % 10 == 0), 1);
        if (idx >= 0) begin
          model(8, 32'(ah[idx]), 32'(bh[idx]), ed, eb, eo);
          chk("t4_diff", 32'(d8), ed);
          chk("t4_flags", {bo8, ov8}, {eb, eo});
        end
      end
      chk("t4_busy_done_excl", busy8 & done8, 0);
      ah[i] = 8'($urandom);
      bh[i] = 8'($urandom);
      a8 = ah[i]; b8 = bh[i]; s8 = 1'b1;
    end
    @(negedge clk);
    s8 = 1'b0;
    chk("t4_count", ndone, 3);
    repeat (12) @(negedge clk);

    // reset in the 4th shift cycle aborts without a done pulse
    run_op(1'b0, 32'd100, 32'd37, dv, bo, ov, lat);
    chk("t5_pre_diff", dv, 63);
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_outs", {busy8, done8, d8, bo8, ov8}, 0);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) stray++;
    end
    chk("t5_no_done", stray, 0);
    run_op(1'b0, 32'h7F, 32'hFF, dv, bo, ov, lat);
    chk("t5_fresh_diff", dv, 32'h80);
    chk("t5_fresh_flags", {bo, ov}, 2'b11);
    chk("t5_fresh_latency", lat, 8);

    for (int i = 0; i < 1000; i++) begin
      ra = 32'($urandom_range(255));
      rb = 32'($urandom_range(255));
      run_op(1'b0, ra, rb, dv, bo, ov, lat);
      model(8, ra, rb, ed, eb, eo);
      chk("rnd8_diff", dv, ed);
      chk("rnd8_flags", {bo, ov}, {eb, eo});
    end

    for (int i = 0; i < 1000; i++) begin
      ra = 32'($urandom_range(8191));
      rb = 32'($urandom_range(8191));
      run_op(1'b1, ra, rb, dv, bo, ov, lat);
      model(13, ra, rb, ed, eb, eo);
      chk("rnd13_diff", dv, ed);
      chk("rnd13_flags", {bo, ov}, {eb, eo});
      if (i == 0) chk("rnd13_latency", lat, 13);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
